// File: rtl/fc_layer_pkg.sv
// Shared types and helpers for the fully-connected layer engine.
// Holds the FSM state encoding, counter sizing and the requantization step.
package fc_layer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_OUT
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-half-up arithmetic shift, optional ReLU, then clamp to a signed dout_dw range.
    function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                   input int                 shift,
                                                   input int                 dout_dw,
                                                   input bit                 relu);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (dout_dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dout_dw - 1));
        if (relu && (r < 0)) begin
            r = '0;
        end
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_layer_engine_mac.sv
// One output lane: CPF products summed into a bias-initialised accumulator,
// with the requantized result registered on the last beat of a group.
module fc_lane_mac
    import fc_layer_pkg::*;
#(
    parameter int CPF        = 4,
    parameter int DIN_DW     = 16,
    parameter int WW         = 4,
    parameter int BIAS_DW    = 4,
    parameter int BIAS_SHIFT = 5,
    parameter int ACC_W      = 40,
    parameter int SHIFT      = 5,
    parameter int DOUT_DW    = 16,
    parameter int RELU       = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     mac_en_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic [CPF*DIN_DW-1:0]    din_i,
    input  logic [CPF*WW-1:0]        wt_i,
    input  logic [BIAS_DW-1:0]       bias_i,
    output logic [DOUT_DW-1:0]       dout_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] prod_sum;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [63:0]      rq;
    logic [DOUT_DW-1:0]      dout_q;

    always_comb begin
        prod_sum = '0;
        for (int c = 0; c < CPF; c++) begin
            prod_sum = prod_sum
                     + ACC_W'($signed(din_i[c*DIN_DW +: DIN_DW]))
                     * ACC_W'($signed(wt_i[c*WW +: WW]));
        end
        // The first beat of a group discards the previous group's total.
        acc_base = first_i ? (ACC_W'($signed(bias_i)) <<< BIAS_SHIFT) : acc_q;
        acc_d    = acc_base + prod_sum;
        rq       = requant(64'(acc_d), SHIFT, DOUT_DW, RELU != 0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            dout_q <= '0;
        end else if (mac_en_i) begin
            acc_q <= acc_d;
            if (last_i) begin
                dout_q <= rq[DOUT_DW-1:0];
            end
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/fc_layer_engine.sv
// Reusable FC compute core: buffers one input vector, then streams weight
// groups against it, emitting KPF requantized outputs per group.
module fc_layer_engine
    import fc_layer_pkg::*;
#(
    parameter int C_IN       = 64,
    parameter int C_OUT      = 10,
    parameter int CPF        = 4,
    parameter int KPF        = 2,
    parameter int DIN_DW     = 16,
    parameter int WW         = 4,
    parameter int BIAS_DW    = 4,
    parameter int BIAS_SHIFT = 5,
    parameter int ACC_W      = 40,
    parameter int SHIFT      = 5,
    parameter int DOUT_DW    = 16,
    parameter int RELU       = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      din_valid_i,
    output logic                      din_rdy_o,
    input  logic [CPF*DIN_DW-1:0]     din_i,
    input  logic                      din_eop_i,
    input  logic                      wt_valid_i,
    output logic                      wt_rdy_o,
    input  logic [KPF*CPF*WW-1:0]     wt_i,
    input  logic [KPF*BIAS_DW-1:0]    wt_bias_i,
    output logic                      dout_valid_o,
    input  logic                      dout_rdy_i,
    output logic [KPF*DOUT_DW-1:0]    dout_o,
    output logic                      dout_eop_o,
    output logic                      busy_o,
    output logic                      err_eop_o
);

    localparam int NB = C_IN / CPF;
    localparam int NG = C_OUT / KPF;
    localparam int BW = cnt_width(NB);
    localparam int GW = cnt_width(NG);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(NB - 1);
    localparam logic [GW-1:0] LAST_GROUP = GW'(NG - 1);

    state_e          state_q;
    logic [BW-1:0]   beat_q;
    logic [GW-1:0]   group_q;
    logic            din_rdy_q;
    logic            wt_rdy_q;
    logic            dout_valid_q;
    logic            dout_eop_q;
    logic            busy_q;
    logic            err_eop_q;
    logic [CPF*DIN_DW-1:0] buf_q [NB];

    logic din_hs;
    logic wt_hs;
    logic dout_hs;
    logic eop_bad;
    logic last_beat;

    assign din_hs    = din_valid_i & din_rdy_q;
    assign wt_hs     = wt_valid_i & wt_rdy_q;
    assign dout_hs   = dout_valid_q & dout_rdy_i;
    assign last_beat = (beat_q == LAST_BEAT);
    assign eop_bad   = din_eop_i != last_beat;

    // Framing is driven purely by the beat counter; din_eop only feeds the error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            group_q      <= '0;
            din_rdy_q    <= 1'b1;
            wt_rdy_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_eop_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_eop_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (din_hs) begin
                        busy_q <= 1'b1;
                        if (eop_bad) begin
                            err_eop_q <= 1'b1;
                        end
                        if (last_beat) begin
                            state_q   <= ST_COMPUTE;
                            beat_q    <= '0;
                            group_q   <= '0;
                            din_rdy_q <= 1'b0;
                            wt_rdy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                            beat_q  <= beat_q + BW'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (wt_hs) begin
                        if (last_beat) begin
                            state_q      <= ST_OUT;
                            beat_q       <= '0;
                            wt_rdy_q     <= 1'b0;
                            dout_valid_q <= 1'b1;
                            dout_eop_q   <= (group_q == LAST_GROUP);
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (dout_hs) begin
                        dout_valid_q <= 1'b0;
                        dout_eop_q   <= 1'b0;
                        if (group_q == LAST_GROUP) begin
                            state_q   <= ST_IDLE;
                            group_q   <= '0;
                            din_rdy_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            state_q  <= ST_COMPUTE;
                            group_q  <= group_q + GW'(1);
                            wt_rdy_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (din_hs) begin
            buf_q[beat_q] <= din_i;
        end
    end

    for (genvar k = 0; k < KPF; k++) begin : g_lane
        fc_lane_mac #(
            .CPF        (CPF),
            .DIN_DW     (DIN_DW),
            .WW         (WW),
            .BIAS_DW    (BIAS_DW),
            .BIAS_SHIFT (BIAS_SHIFT),
            .ACC_W      (ACC_W),
            .SHIFT      (SHIFT),
            .DOUT_DW    (DOUT_DW),
            .RELU       (RELU)
        ) u_mac (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .mac_en_i (wt_hs),
            .first_i  (beat_q == '0),
            .last_i   (last_beat),
            .din_i    (buf_q[beat_q]),
            .wt_i     (wt_i[k*CPF*WW +: CPF*WW]),
            .bias_i   (wt_bias_i[k*BIAS_DW +: BIAS_DW]),
            .dout_o   (dout_o[k*DOUT_DW +: DOUT_DW])
        );
    end

    assign din_rdy_o    = din_rdy_q;
    assign wt_rdy_o     = wt_rdy_q;
    assign dout_valid_o = dout_valid_q;
    assign dout_eop_o   = dout_eop_q;
    assign busy_o       = busy_q;
    assign err_eop_o    = err_eop_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine with default sizing (NB=16, NG=5);
// a second instance with RELU=1 shares all inputs.
module tb_fc_layer_engine;

    localparam int NB       = 16;
    localparam int NG       = 5;
    localparam int MAX_WAIT = 50;

    logic        clk = 1'b0;
    logic        rstN;
    logic        dinValid;
    logic [63:0] din;
    logic        dinEop;
    logic        wtValid;
    logic [31:0] wt;
    logic [7:0]  wtBias;
    logic        doutRdy;

    logic        dinRdy, wtRdy, doutValid, doutEop, busy, errEop;
    logic [31:0] dout;
    logic        dinRdyR, wtRdyR, doutValidR, doutEopR, busyR, errEopR;
    logic [31:0] doutR;

    logic [63:0] dinMem  [NB];
    logic [31:0] wtMem   [NG][NB];
    logic [7:0]  biasMem [NG];
    logic [31:0] gotDout [NG];
    logic [31:0] gotDoutR[NG];
    logic        gotEop  [NG];
    int          holdViol, extraBeats, latencyErr;
    logic        busyBefore, busyAfter, errBeforeAbort;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    fc_layer_engine dut (
        .clk_i(clk), .rst_ni(rstN),
        .din_valid_i(dinValid), .din_rdy_o(dinRdy), .din_i(din), .din_eop_i(dinEop),
        .wt_valid_i(wtValid), .wt_rdy_o(wtRdy), .wt_i(wt), .wt_bias_i(wtBias),
        .dout_valid_o(doutValid), .dout_rdy_i(doutRdy), .dout_o(dout), .dout_eop_o(doutEop),
        .busy_o(busy), .err_eop_o(errEop)
    );

    fc_layer_engine #(.RELU(1)) dutRelu (
        .clk_i(clk), .rst_ni(rstN),
        .din_valid_i(dinValid), .din_rdy_o(dinRdyR), .din_i(din), .din_eop_i(dinEop),
        .wt_valid_i(wtValid), .wt_rdy_o(wtRdyR), .wt_i(wt), .wt_bias_i(wtBias),
        .dout_valid_o(doutValidR), .dout_rdy_i(doutRdy), .dout_o(doutR), .dout_eop_o(doutEopR),
        .busy_o(busyR), .err_eop_o(errEopR)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeoutFail(input string what);
        checks++;
        $display("[TB] FAIL timeout_%s: no handshake after %0d cycles, required one", what, MAX_WAIT);
    endtask

    task automatic setOnes();
        for (int b = 0; b < NB; b++) begin
            dinMem[b] = {4{16'd32}};
            for (int g = 0; g < NG; g++) wtMem[g][b] = 32'h1111_1111;
        end
        for (int g = 0; g < NG; g++) biasMem[g] = 8'h00;
    endtask

    task automatic setUniform(input logic [15:0] d, input logic [3:0] w);
        for (int b = 0; b < NB; b++) begin
            dinMem[b] = {4{d}};
            for (int g = 0; g < NG; g++) wtMem[g][b] = {8{w}};
        end
        for (int g = 0; g < NG; g++) biasMem[g] = 8'h00;
    endtask

    // Drives one whole frame and records what came out; aborts with reset at (abortGroup, abortBeat).
    task automatic runFrame(input int eopBeat, input bit stall, input int holdGroup,
                            input int holdCycles, input int abortGroup, input int abortBeat);
        int guard;
        holdViol = 0;
        extraBeats = 0;
        latencyErr = 0;
        for (int b = 0; b < NB; b++) begin
            while (stall && ($urandom_range(1, 0) == 1)) tick();
            dinValid = 1'b1;
            din      = dinMem[b];
            dinEop   = (b == eopBeat);
            guard = 0;
            while (!dinRdy && guard < MAX_WAIT) begin tick(); guard++; end
            if (!dinRdy) timeoutFail("din_rdy");
            tick();
            dinValid = 1'b0;
            dinEop   = 1'b0;
        end
        for (int g = 0; g < NG; g++) begin
            for (int b = 0; b < NB; b++) begin
                if (g == abortGroup && b == abortBeat) begin
                    wtValid = 1'b0;
                    errBeforeAbort = errEop;
                    rstN = 1'b0;
                    #2;
                    return;
                end
                while (stall && ($urandom_range(1, 0) == 1)) begin
                    if (doutValid) extraBeats++;
                    tick();
                end
                wtValid = 1'b1;
                wt      = wtMem[g][b];
                wtBias  = (b == 0) ? biasMem[g] : ~biasMem[g];
                guard = 0;
                while (!wtRdy && guard < MAX_WAIT) begin tick(); guard++; end
                if (!wtRdy) timeoutFail("wt_rdy");
                if (doutValid) extraBeats++;
                tick();
                wtValid = 1'b0;
            end
            if (!doutValid) latencyErr++;
            guard = 0;
            while (!doutValid && guard < MAX_WAIT) begin tick(); guard++; end
            if (!doutValid) timeoutFail("dout_valid");
            busyBefore  = busy;
            gotDout[g]  = dout;
            gotDoutR[g] = doutR;
            gotEop[g]   = doutEop;
            if (g == holdGroup) begin
                for (int i = 0; i < holdCycles; i++) begin
                    tick();
                    if (dout !== gotDout[g] || doutEop !== gotEop[g] || wtRdy !== 1'b0 || doutValid !== 1'b1)
                        holdViol++;
                end
            end
            doutRdy = 1'b1;
            tick();
            doutRdy = 1'b0;
            if (doutValid) extraBeats++;
        end
        busyAfter = busy;
    endtask

    task automatic test_reset();
        checks++;
        if ({dinRdy, wtRdy, doutValid, doutEop, busy, errEop} !== 6'b100000)
            $display("[TB] FAIL reset_ctrl: got %b expected 100000", {dinRdy, wtRdy, doutValid, doutEop, busy, errEop});
        else passes++;
        checks++;
        if (dout !== 32'h0) $display("[TB] FAIL reset_dout: got %h expected 00000000", dout);
        else passes++;
        checks++;
        if ({dinRdyR, wtRdyR, doutValidR, doutEopR, busyR, errEopR, doutR} !== {6'b100000, 32'h0})
            $display("[TB] FAIL reset_relu: got %b/%h expected 100000/00000000",
                     {dinRdyR, wtRdyR, doutValidR, doutEopR, busyR, errEopR}, doutR);
        else passes++;
    endtask

    task automatic test_ones();
        setOnes();
        runFrame(15, 1'b0, -1, 0, -1, -1);
        for (int g = 0; g < NG; g++) begin
            checks++;
            if (gotDout[g] !== 32'h0040_0040) $display("[TB] FAIL ones_dout g%0d: got %h expected 00400040", g, gotDout[g]);
            else passes++;
            checks++;
            if (gotEop[g] !== (g == NG - 1)) $display("[TB] FAIL ones_eop g%0d: got %b expected %b", g, gotEop[g], g == NG - 1);
            else passes++;
        end
        checks++;
        if (gotDoutR[NG-1] !== 32'h0040_0040) $display("[TB] FAIL ones_relu: got %h expected 00400040", gotDoutR[NG-1]);
        else passes++;
        checks++;
        if (latencyErr !== 0) $display("[TB] FAIL ones_latency: got %0d late groups expected 0", latencyErr);
        else passes++;
        checks++;
        if ({busyBefore, busyAfter, errEop} !== 3'b100) $display("[TB] FAIL ones_busy_err: got %b expected 100", {busyBefore, busyAfter, errEop});
        else passes++;
    endtask

    task automatic test_saturation();
        setUniform(16'h7FFF, 4'h7);
        runFrame(15, 1'b0, -1, 0, -1, -1);
        checks++;
        if (gotDout[0] !== 32'h7FFF_7FFF) $display("[TB] FAIL sat_pos: got %h expected 7fff7fff", gotDout[0]);
        else passes++;
        checks++;
        if (gotDoutR[3] !== 32'h7FFF_7FFF) $display("[TB] FAIL sat_pos_relu: got %h expected 7fff7fff", gotDoutR[3]);
        else passes++;
        setUniform(16'h7FFF, 4'h8);
        runFrame(15, 1'b0, -1, 0, -1, -1);
        checks++;
        if (gotDout[1] !== 32'h8000_8000) $display("[TB] FAIL sat_neg: got %h expected 80008000", gotDout[1]);
        else passes++;
        checks++;
        if (gotDoutR[1] !== 32'h0) $display("[TB] FAIL sat_neg_relu: got %h expected 00000000", gotDoutR[1]);
        else passes++;
    endtask

    task automatic test_rounding();
        logic [31:0] expMain [NG];
        logic [31:0] expRelu [NG];
        expMain = '{32'h0000_0000, 32'h0001_0001, 32'h0001_0001, 32'hFFFF_FFFF, 32'h0002_0000};
        expRelu = '{32'h0000_0000, 32'h0001_0001, 32'h0001_0001, 32'h0000_0000, 32'h0002_0000};
        setUniform(16'h0, 4'h0);
        dinMem[0]  = 64'h0000_0000_0010_000F;
        wtMem[0][0] = 32'h0001_0001;
        wtMem[1][0] = 32'h0010_0010;
        biasMem[2]  = 8'h11;
        biasMem[3]  = 8'hFF;
        wtMem[4][0] = 32'h0010_00F0;
        biasMem[4]  = 8'h10;
        runFrame(15, 1'b0, -1, 0, -1, -1);
        for (int g = 0; g < NG; g++) begin
            checks++;
            if (gotDout[g] !== expMain[g]) $display("[TB] FAIL round_dout g%0d: got %h expected %h", g, gotDout[g], expMain[g]);
            else passes++;
            checks++;
            if (gotDoutR[g] !== expRelu[g]) $display("[TB] FAIL round_relu g%0d: got %h expected %h", g, gotDoutR[g], expRelu[g]);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        setOnes();
        runFrame(15, 1'b0, 2, 10, -1, -1);
        checks++;
        if (holdViol !== 0) $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", holdViol);
        else passes++;
        checks++;
        if (extraBeats !== 0) $display("[TB] FAIL bp_extra: got %0d extra beats expected 0", extraBeats);
        else passes++;
        for (int g = 0; g < NG; g++) begin
            checks++;
            if (gotDout[g] !== 32'h0040_0040 || gotEop[g] !== (g == NG - 1))
                $display("[TB] FAIL bp_dout g%0d: got %h/%b expected 00400040/%b", g, gotDout[g], gotEop[g], g == NG - 1);
            else passes++;
        end
    endtask

    task automatic test_stalls();
        setOnes();
        runFrame(15, 1'b1, -1, 0, -1, -1);
        for (int g = 0; g < NG; g++) begin
            checks++;
            if (gotDout[g] !== 32'h0040_0040) $display("[TB] FAIL stall_dout g%0d: got %h expected 00400040", g, gotDout[g]);
            else passes++;
        end
        checks++;
        if ({busyBefore, busyAfter, dinRdy} !== 3'b101) $display("[TB] FAIL stall_busy: got %b expected 101", {busyBefore, busyAfter, dinRdy});
        else passes++;
        checks++;
        if (extraBeats !== 0) $display("[TB] FAIL stall_extra: got %0d extra beats expected 0", extraBeats);
        else passes++;
    endtask

    task automatic test_err_eop();
        setOnes();
        runFrame(9, 1'b0, -1, 0, -1, -1);
        checks++;
        if (errEop !== 1'b1) $display("[TB] FAIL err_set: got %b expected 1", errEop);
        else passes++;
        checks++;
        if (gotDout[0] !== 32'h0040_0040 || gotDout[4] !== 32'h0040_0040)
            $display("[TB] FAIL err_dout: got %h/%h expected 00400040/00400040", gotDout[0], gotDout[4]);
        else passes++;
        repeat (3) tick();
        checks++;
        if (errEop !== 1'b1) $display("[TB] FAIL err_held: got %b expected 1", errEop);
        else passes++;
    endtask

    task automatic test_reset_abort();
        setOnes();
        runFrame(15, 1'b0, -1, 0, 2, 7);
        checks++;
        if (errBeforeAbort !== 1'b1) $display("[TB] FAIL abort_err_before: got %b expected 1", errBeforeAbort);
        else passes++;
        checks++;
        if ({dinRdy, wtRdy, doutValid, doutEop, busy, errEop} !== 6'b100000 || dout !== 32'h0 || doutR !== 32'h0)
            $display("[TB] FAIL abort_outputs: got %b/%h/%h expected 100000/00000000/00000000",
                     {dinRdy, wtRdy, doutValid, doutEop, busy, errEop}, dout, doutR);
        else passes++;
        tick();
        tick();
        rstN = 1'b1;
        tick();
        runFrame(15, 1'b0, -1, 0, -1, -1);
        for (int g = 0; g < NG; g++) begin
            checks++;
            if (gotDout[g] !== 32'h0040_0040) $display("[TB] FAIL abort_recover g%0d: got %h expected 00400040", g, gotDout[g]);
            else passes++;
        end
        checks++;
        if (errEop !== 1'b0) $display("[TB] FAIL abort_err_after: got %b expected 0", errEop);
        else passes++;
    endtask

    initial begin
        rstN     = 1'b0;
        dinValid = 1'b0;
        din      = '0;
        dinEop   = 1'b0;
        wtValid  = 1'b0;
        wt       = '0;
        wtBias   = '0;
        doutRdy  = 1'b0;
        tick();
        tick();
        test_reset();
        rstN = 1'b1;
        tick();
        test_ones();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_stalls();
        test_err_eop();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fc_layer_engine.md
# fc_layer_engine

Parametrised fully-connected compute core for the quantized CIFAR-10 accelerator. It buffers one input vector of C_IN activations, then streams C_OUT/KPF weight groups against it. Each group produces KPF requantized outputs with rounding, saturation and optional ReLU. It sits between the blob input stream and the next layer or the output DMA, replacing fixed-size FC layers with one reusable block.

## Interface
- C_IN, 64: input channels; C_IN % CPF == 0.
- C_OUT, 10: output channels; C_OUT % KPF == 0.
- CPF, 4: input lanes per beat.
- KPF, 2: outputs computed in parallel.
- DIN_DW, 16: signed activation width.
- WW, 4: signed weight width.
- BIAS_DW, 4: signed bias width.
- BIAS_SHIFT, 5: left shift applied to bias before accumulation.
- ACC_W, 40: accumulator width.
- SHIFT, 5: requant right shift, ≥1.
- DOUT_DW, 16: signed output width.
- RELU, 0: 1 clamps negative results to 0.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- din_valid / din_rdy  in / out  1  input vector handshake.
- din  in  CPF*DIN_DW  lane c at [c*DIN_DW +: DIN_DW].
- din_eop  in  1  marks last input beat.
- wt_valid / wt_rdy  in / out  1  weight handshake.
- wt  in  KPF*CPF*WW  weight for output k, lane c at [(k*CPF+c)*WW +: WW].
- wt_bias  in  KPF*BIAS_DW  bias k at [k*BIAS_DW +: BIAS_DW]; sampled on the first wt beat of each group only.
- dout_valid / dout_rdy  out / in  1  output handshake.
- dout  out  KPF*DOUT_DW  output k at [k*DOUT_DW +: DOUT_DW].
- dout_eop  out  1  set on the last group.
- busy  out  1  high whenever state ≠ IDLE.
- err_eop  out  1  sticky din_eop framing error.

## Operation
- NB = C_IN/CPF beats per vector; NG = C_OUT/KPF groups.
- States: IDLE, LOAD, COMPUTE, OUT.
- IDLE:
  - din_rdy = 1.
  - The first din handshake writes buffer[0] and moves to LOAD; if NB == 1, it moves directly to COMPUTE.
- LOAD:
  - din_rdy = 1; each handshake writes buffer[beat].
  - On beat NB-1, the state moves to COMPUTE with g = 0 and beat = 0.
- din_eop framing:
  - din_eop is expected exactly on beat NB-1.
  - If it is asserted on any other beat, or absent on beat NB-1, err_eop sets.
  - Framing always follows the beat counter; din_eop never changes framing.
- COMPUTE:
  - wt_rdy = 1; din_rdy = 0.
  - The buffer is a register array with combinational read at index beat.
  - On each wt handshake, for every k: acc_k += Σ_c din[c]·wt[k][c], signed and sign-extended to ACC_W.
  - On beat 0, acc_k is first loaded with sext(wt_bias_k) << BIAS_SHIFT.
  - On beat NB-1, the state moves to OUT and the requantized result is registered into dout.
- Requantization, per output:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT.
  - If RELU = 1 and r < 0, r = 0.
  - r saturates to [-2^(DOUT_DW-1), 2^(DOUT_DW-1)-1].
- OUT:
  - dout_valid = 1; dout_eop = (g == NG-1).
  - On dout_rdy, g increments and the state returns to COMPUTE, or to IDLE if g == NG-1.
- Overflow of ACC_W is not detected; ACC_W must be sized by the integrator.

## Timing
- Reset values: all outputs 0 except din_rdy, which is 1 because the block resets into IDLE. Buffer contents are don't-care.
- Reset asserted mid-operation aborts everything and returns to IDLE; err_eop clears.
- Latency: last wt handshake at cycle t gives dout_valid at t+1.
- Throughput: one weight beat per cycle, so a frame takes NB + NG·(NB+1) cycles when there is no backpressure.
- dout and dout_eop stay stable while dout_valid=1 and dout_rdy=0; wt_rdy is 0 in OUT.
- wt_valid gaps stall accumulation without changing results.
- A new vector is accepted only after the final group handshake.

## Structure
- Package fc_layer_pkg:
  - state enum;
  - functions clog2-based counter widths;
  - round/ReLU/saturate function.
- Sub-module fc_lane_mac, instantiated KPF times:
  - CPF multipliers, adder tree, accumulator, bias init, requant register.
- The top level holds the FSM, counters, input buffer and handshakes.

## Test plan
All scenarios use the default parameters: NB=16, NG=5.
1. Ones: din lanes=32, all weights=+1, bias=0 → five beats with every dout=64; dout_eop only on the 5th.
2. Saturation and ReLU:
   - din=32767 with w=+7 → 32767.
   - din=32767 with w=-8 → -32768.
   - Same as the w=-8 case with RELU=1 → 0.
3. Rounding and bias:
   - A single nonzero product of 15 → 0.
   - A single product of 16 → 1.
   - bias=+1 with zero data → 1.
   - bias=-1 with zero data → -1.
4. Backpressure: dout_rdy held low for 10 cycles on group 2 → dout stable, wt_rdy=0, no extra beats, final values as in scenario 1.
5. Stalls: wt_valid and din_valid randomly 50% duty → outputs bit-identical to scenario 1; busy drops exactly after the 5th dout handshake.
6. Errors and reset:
   - din_eop on beat 9 → err_eop=1 and held; outputs are still computed.
   - rst low during group 2, beat 7 → all outputs 0, err_eop cleared; the next frame gives correct results.
